button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 18 +
 rtl/button_conditioner_if.sv | 30 +++
 rtl/button_conditioner_sync_2ff.sv | 26 ++
 rtl/button_conditioner.sv | 127 ++++++++++++
 tb/tb_button_conditioner.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// button_pkg: shared types and default timing constants for the push-button
// conditioner.
//   btn_state_t            debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEF    default stable-sample count to accept a press/release
//   LONG_PRESS_CYCLES_DEF  default hold time after the press pulse for long_press
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 16;
    localparam int unsigned LONG_PRESS_CYCLES_DEF = 1000;

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pad-side input and conditioned outputs of the
// push-button conditioner.
//   button_raw    raw, asynchronous, bouncing pad level
//   button_pulse  one-cycle pulse per accepted press
//   button_level  debounced button state
//   long_press    one-cycle pulse when a press has been held long enough
// Modports: master drives the pad and observes the outputs; slave is the
// conditioner itself.
interface button_conditioner_if;

    logic button_raw;
    logic button_pulse;
    logic button_level;
    logic long_press;

    modport master (
        output button_raw,
        input  button_pulse,
        input  button_level,
        input  long_press
    );

    modport slave (
        input  button_raw,
        output button_pulse,
        output button_level,
        output long_press
    );

endinterface

// File: rtl/button_conditioner_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for an asynchronous pad input.
//   clk  destination clock
//   rst  asynchronous, active-high reset; both stages clear to 0
//   d    asynchronous input
//   q    synchronised output, two edges after d is sampled
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic stage1;

    // First stage may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= 1'b0;
            q      <= 1'b0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects a push button
// for the downstream sequencing controller.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   btn   slave side of button_conditioner_if:
//           button_raw   (in)  raw pad level
//           button_pulse (out) one cycle per accepted press
//           button_level (out) debounced state, high in HELD/RELEASE_CHK
//           long_press   (out) one cycle, LONG_PRESS_CYCLES edges after the
//                              press pulse if still held, at most once a press
// All outputs are registered; nothing combinational runs from button_raw.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    button_conditioner_if.slave btn
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_PRESS_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_CYCLES - 1);

    btn_state_t        state;
    logic [DCNT_W-1:0] dcnt;
    logic [HCNT_W-1:0] hcnt;
    logic              sync2;
    logic              pulse;
    logic              level;
    logic              long_hit;

    // Bring the pad into the clk domain; only the second stage is used.
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn.button_raw),
        .q   (sync2)
    );

    // Debounce FSM, stability/hold counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dcnt     <= '0;
            hcnt     <= '0;
            pulse    <= 1'b0;
            level    <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            pulse    <= 1'b0;
            long_hit <= 1'b0;

            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= PRESS_CHK;
                        dcnt  <= '0;
                    end
                end

                PRESS_CHK: begin
                    if (!sync2) begin
                        // Bounce: drop back without any output.
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_LAST) begin
                        state <= HELD;
                        dcnt  <= '0;
                        hcnt  <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end

                HELD: begin
                    if (!sync2) begin
                        state <= RELEASE_CHK;
                        dcnt  <= '0;
                    end
                end

                RELEASE_CHK: begin
                    if (sync2) begin
                        // Release bounce: resume the same press, hold time kept.
                        state <= HELD;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_LAST) begin
                        state <= IDLE;
                        dcnt  <= '0;
                        level <= 1'b0;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    dcnt  <= '0;
                    level <= 1'b0;
                end
            endcase

            // Hold timer saturates, so long_press can fire only once per press.
            if (state == HELD || state == RELEASE_CHK) begin
                if (hcnt != HCNT_MAX) begin
                    hcnt <= hcnt + HCNT_W'(1);
                end
                if (hcnt == HCNT_LAST) begin
                    long_hit <= 1'b1;
                end
            end
        end
    end

    assign btn.button_pulse = pulse;
    assign btn.button_level = level;
    assign btn.long_press   = long_hit;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a scoreboard of expected
// output events (kind + edge number); a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned LP  = 10;

    typedef enum int {EV_PULSE, EV_RISE, EV_FALL, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       edge_no;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;
    logic prev_level = 1'b0;
    ev_t  exp_q[$];

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bif)
    );

    always #5 clk = ~clk;

    // Edge index: value seen at a negedge is the number of the last rising edge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void expect_ev(ev_kind_t k, int e);
        ev_t ev;
        ev.kind    = k;
        ev.edge_no = e;
        exp_q.push_back(ev);
    endfunction

    function automatic void observe(ev_kind_t k);
        ev_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s at edge %0d, required no event",
                     k.name(), edge_cnt);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != k || ev.edge_no != edge_cnt) begin
                failures++;
                $display("FAIL event_order: got %s at edge %0d, required %s at edge %0d",
                         k.name(), edge_cnt, ev.kind.name(), ev.edge_no);
            end
        end
    endfunction

    function automatic void check_bit(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endfunction

    // Monitor: every output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (bif.button_pulse === 1'b1)                   observe(EV_PULSE);
        if (bif.button_level === 1'b1 && !prev_level)    observe(EV_RISE);
        if (bif.button_level !== 1'b1 && prev_level)     observe(EV_FALL);
        if (bif.long_press === 1'b1)                     observe(EV_LONG);
        prev_level = (bif.button_level === 1'b1);
    end

    // Drive the pad level at n consecutive negedges.
    task automatic hold(input logic v, input int n);
        repeat (n) begin
            bif.button_raw = v;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int r0;

        rst            = 1'b1;
        bif.button_raw = 1'b0;
        #1;
        check_bit("reset_pulse", bif.button_pulse, 1'b0);
        check_bit("reset_level", bif.button_level, 1'b0);
        check_bit("reset_long",  bif.long_press,   1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 4);

        // Clean press held 30 cycles: pulse/level at +6, long_press at +16.
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_LONG,  e0 + 16);
        hold(1'b1, 30);
        r0 = edge_cnt + 1;
        expect_ev(EV_FALL, r0 + 6);
        hold(1'b0, 12);

        // Bouncy press 1,0,1,1,0,1 then steady: counted from the final 1.
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 1);
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_LONG,  e0 + 16);
        hold(1'b1, 25);
        r0 = edge_cnt + 1;
        expect_ev(EV_FALL, r0 + 6);
        hold(1'b0, 12);

        // Glitch of DEB-1 cycles: no events at all.
        hold(1'b1, 3);
        hold(1'b0, 15);

        // Release bounce of 2 cycles: level stays up, hold time not restarted.
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_LONG,  e0 + 16);
        hold(1'b1, 9);
        hold(1'b0, 2);
        hold(1'b1, 12);
        r0 = edge_cnt + 1;
        expect_ev(EV_FALL, r0 + 6);
        hold(1'b0, 12);

        // Short press: release completes 8 edges after the pulse, before the
        // hold count can reach LP, so no long_press; then a second press.
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_FALL,  e0 + 14);
        hold(1'b1, 8);
        hold(1'b0, 14);
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_FALL,  e0 + 14);
        hold(1'b1, 8);
        hold(1'b0, 14);

        // Reset 3 cycles after the pulse with the button still held.
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        hold(1'b1, 10);
        #1;
        rst = 1'b1;
        expect_ev(EV_FALL, e0 + 10);
        #1;
        check_bit("midrst_pulse", bif.button_pulse, 1'b0);
        check_bit("midrst_level", bif.button_level, 1'b0);
        check_bit("midrst_long",  bif.long_press,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e0 = edge_cnt + 1;
        expect_ev(EV_PULSE, e0 + 6);
        expect_ev(EV_RISE,  e0 + 6);
        expect_ev(EV_LONG,  e0 + 16);
        hold(1'b1, 20);
        r0 = edge_cnt + 1;
        expect_ev(EV_FALL, r0 + 6);
        hold(1'b0, 12);

        // Every expected event must have been seen.
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d unmatched, required 0", exp_q.size());
            foreach (exp_q[i])
                $display("FAIL missing_event: %s at edge %0d never seen",
                         exp_q[i].kind.name(), exp_q[i].edge_no);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
